// File: rtl/cpu_pkg.sv
// cpu_pkg: shared skid-buffer state encoding and write-back constant-source defaults.
package cpu_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} skid_state_e;
  localparam int CONST_VAL_DEF = 227;
  localparam int CONST_IDX_DEF = 8;
endpackage

// File: rtl/wb_src_decode.sv
// wb_src_decode: maps a select code to a source word, the built-in constant, or zero for illegal codes.
module wb_src_decode import cpu_pkg::*; #(
  parameter int WIDTH     = 32,
  parameter int NSRC      = 11,
  parameter int SEL_W     = 4,
  parameter int CONST_VAL = CONST_VAL_DEF,
  parameter int CONST_IDX = CONST_IDX_DEF
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic [NSRC*WIDTH-1:0] src_bus,
  output logic [WIDTH-1:0]      data,
  output logic                  illegal
);
  logic [WIDTH-1:0] cand [2**SEL_W];
  // Codes above the constant slot reach one source lower, since the constant steals a code.
  for (genvar g = 0; g < 2**SEL_W; g++) begin : g_cand
    if (g < CONST_IDX && g < NSRC) begin : g_lo
      assign cand[g] = src_bus[g*WIDTH +: WIDTH];
    end else if (g == CONST_IDX) begin : g_k
      assign cand[g] = WIDTH'(CONST_VAL);
    end else if (g > CONST_IDX && g <= NSRC) begin : g_hi
      assign cand[g] = src_bus[(g-1)*WIDTH +: WIDTH];
    end else begin : g_z
      assign cand[g] = '0;
    end
  end
  assign data    = cand[sel];
  assign illegal = sel > SEL_W'(NSRC);
endmodule

// File: rtl/wb_select_stage.sv
// wb_select_stage: selects a write-back source and passes it through a 2-entry skid buffer
// with registered in_ready, register-0 write suppression and a saturating illegal-select counter.
module wb_select_stage import cpu_pkg::*; #(
  parameter int WIDTH     = 32,
  parameter int NSRC      = 11,
  parameter int SEL_W     = 4,
  parameter int CONST_VAL = CONST_VAL_DEF,
  parameter int CONST_IDX = CONST_IDX_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic [NSRC*WIDTH-1:0] src_bus,
  input  logic [4:0]            in_dst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [4:0]            out_dst,
  output logic                  out_we,
  output logic                  sel_err,
  output logic [7:0]            err_count
);
  skid_state_e      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic [4:0]       head_dst_q, head_dst_d, skid_dst_q, skid_dst_d;
  logic             sel_err_q, sel_err_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [WIDTH-1:0] sel_data;
  logic             sel_illegal, accept, drain;

  wb_src_decode #(
    .WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W), .CONST_VAL(CONST_VAL), .CONST_IDX(CONST_IDX)
  ) u_dec (
    .sel(sel), .src_bus(src_bus), .data(sel_data), .illegal(sel_illegal)
  );

  assign accept    = in_valid && in_ready_q;
  assign out_valid = state_q != ST_EMPTY;
  assign drain     = out_valid && out_ready;
  assign in_ready  = in_ready_q;
  assign out_data  = head_data_q;
  assign out_dst   = head_dst_q;
  assign out_we    = !reset && drain && (head_dst_q != 5'd0);
  assign sel_err   = sel_err_q;
  assign err_count = err_count_q;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_dst_d  = head_dst_q;
    skid_data_d = skid_data_q;
    skid_dst_d  = skid_dst_q;
    unique case (state_q)
      ST_EMPTY: if (accept) begin
        state_d     = ST_ONE;
        head_data_d = sel_data;
        head_dst_d  = in_dst;
      end
      ST_ONE: if (accept && drain) begin
        head_data_d = sel_data;
        head_dst_d  = in_dst;
      end else if (accept) begin
        state_d     = ST_FULL;
        skid_data_d = sel_data;
        skid_dst_d  = in_dst;
      end else if (drain) begin
        state_d = ST_EMPTY;
      end
      ST_FULL: if (drain) begin
        state_d     = ST_ONE;
        head_data_d = skid_data_q;
        head_dst_d  = skid_dst_q;
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d  = state_d != ST_FULL;
    sel_err_d   = accept && sel_illegal;
    err_count_d = (sel_err_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      head_data_q <= '0;
      head_dst_q  <= '0;
      skid_data_q <= '0;
      skid_dst_q  <= '0;
      sel_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      head_data_q <= head_data_d;
      head_dst_q  <= head_dst_d;
      skid_data_q <= skid_data_d;
      skid_dst_q  <= skid_dst_d;
      sel_err_q   <= sel_err_d;
      err_count_q <= err_count_d;
    end
  end
endmodule

// File: tb/tb_wb_select_stage.sv
// tb_wb_select_stage: table-driven select sweep plus directed skid-buffer, error and reset sequences.
module tb_wb_select_stage;
  localparam int WIDTH = 32;
  localparam int NSRC  = 11;
  localparam int SEL_W = 4;

  logic                  clk = 1'b0;
  logic                  reset, in_valid, out_ready;
  logic                  in_ready, out_valid, out_we, sel_err;
  logic [SEL_W-1:0]      sel;
  logic [NSRC*WIDTH-1:0] src_bus;
  logic [4:0]            in_dst, out_dst;
  logic [WIDTH-1:0]      out_data;
  logic [7:0]            err_count;

  int vectors = 0;
  int fails   = 0;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [4:0]       dst;
    logic [WIDTH-1:0] data;
    logic             err;
  } vec_t;

  vec_t tbl[15];

  wb_select_stage #(.WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .src_bus(src_bus), .in_dst(in_dst), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_dst(out_dst), .out_we(out_we), .sel_err(sel_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NSRC; k++) src_bus[k*WIDTH +: WIDTH] = 32'h1000 + k;
    for (int k = 0; k < 8; k++) tbl[k] = '{SEL_W'(k), 5'(k + 1), 32'h1000 + k, 1'b0};
    tbl[8]  = '{4'd8,  5'd9,  32'd227,     1'b0};
    tbl[9]  = '{4'd9,  5'd10, 32'h1008,    1'b0};
    tbl[10] = '{4'd10, 5'd11, 32'h1009,    1'b0};
    tbl[11] = '{4'd11, 5'd12, 32'h100A,    1'b0};
    tbl[12] = '{4'd15, 5'd13, 32'h0,       1'b1};
    tbl[13] = '{4'd12, 5'd14, 32'h0,       1'b1};
    tbl[14] = '{4'd2,  5'd15, 32'h1002,    1'b0};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = '0; in_dst = '0;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_dst",   out_dst,   0);
    chk("rst_sel_err",   sel_err,   0);
    chk("rst_err_count", err_count, 0);
    chk("rst_out_we",    out_we,    0);
    reset = 1'b0;

    // Streaming sweep: every accept drains the previous item the same cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; sel = tbl[i].sel; in_dst = tbl[i].dst;
      step();
      chk($sformatf("sweep%0d_valid", i), out_valid, 1);
      chk($sformatf("sweep%0d_data",  i), out_data,  tbl[i].data);
      chk($sformatf("sweep%0d_dst",   i), out_dst,   32'(tbl[i].dst));
      chk($sformatf("sweep%0d_err",   i), sel_err,   32'(tbl[i].err));
    end
    in_valid = 1'b0;
    step();
    chk("sweep_drained", out_valid, 0);
    chk("sweep_err_count", err_count, 2);

    // Backpressure: third offer must be refused while full.
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 4'd0; in_dst = 5'd1;
    step();
    chk("bp1_in_ready", in_ready, 1);
    chk("bp1_data", out_data, 32'h1000);
    sel = 4'd1; in_dst = 5'd2;
    step();
    chk("bp2_in_ready", in_ready, 0);
    chk("bp2_data", out_data, 32'h1000);
    sel = 4'd2; in_dst = 5'd3;
    step();
    chk("bp3_in_ready", in_ready, 0);
    chk("bp3_hold_data", out_data, 32'h1000);
    chk("bp3_hold_dst", out_dst, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_we_item1", out_we, 1);
    step();
    chk("bp_item2_valid", out_valid, 1);
    chk("bp_item2_data", out_data, 32'h1001);
    chk("bp_item2_dst", out_dst, 2);
    chk("bp_ready_back", in_ready, 1);
    step();
    chk("bp_no_item3", out_valid, 0);

    // Accept and drain together in ONE keeps ONE with the new item.
    out_ready = 1'b0; in_valid = 1'b1; sel = 4'd3; in_dst = 5'd4;
    step();
    chk("sim_first", out_data, 32'h1003);
    out_ready = 1'b1; sel = 4'd4; in_dst = 5'd6;
    step();
    chk("sim_data", out_data, 32'h1004);
    chk("sim_valid", out_valid, 1);
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("sim_still_one", in_ready, 1);
    chk("sim_hold", out_data, 32'h1004);
    out_ready = 1'b1;
    step();
    chk("sim_empty", out_valid, 0);

    // Register 0 drains without a write strobe.
    out_ready = 1'b0; in_valid = 1'b1; sel = 4'd5; in_dst = 5'd0;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("r0_valid", out_valid, 1);
    chk("r0_we", out_we, 0);
    step();
    out_ready = 1'b0; in_valid = 1'b1; sel = 4'd5; in_dst = 5'd5;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("r5_we", out_we, 1);
    step();

    // Single illegal accept after a clean reset.
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; sel = 4'd15; in_dst = 5'd7;
    step();
    chk("ill_data", out_data, 0);
    chk("ill_pulse", sel_err, 1);
    in_valid = 1'b0;
    step();
    chk("ill_pulse_end", sel_err, 0);
    chk("ill_count", err_count, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    step();
    chk("ill_saturate", err_count, 255);

    // Fill to FULL, offer an illegal code that is not accepted, then reset mid-flight.
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; sel = 4'd15; in_dst = 5'd3;
    step();
    step();
    chk("full_ready", in_ready, 0);
    in_valid = 1'b1; sel = 4'd15;
    step();
    step();
    chk("full_no_err", sel_err, 0);
    chk("full_count", err_count, 2);
    reset = 1'b1; out_ready = 1'b1;
    #1;
    chk("mid_rst_we_during", out_we, 0);
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_count", err_count, 0);
    chk("mid_rst_we", out_we, 0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_we", out_we, 0);
    step();
    chk("post_rst_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
